// File: rtl/fetch_pkg.sv
// Shared types and defaults for the fetch-stage sequencing controller.
package fetch_pkg;

  localparam int unsigned WORD_W = 32;

  typedef logic [WORD_W-1:0] word_t;

  localparam word_t       RESET_PC_DEF   = 32'h0000_0000;
  localparam int unsigned PC_STEP_DEF    = 4;
  localparam int unsigned ALIGN_BITS_DEF = 2;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    FAULT = 2'd3
  } state_t;

endpackage

// File: rtl/fetch_hold_buf.sv
// Registered instruction holding stage between fetch and decode.
module fetch_hold_buf
  import fetch_pkg::*;
(
  input  logic  clk,
  input  logic  reset,
  input  logic  capture,
  input  logic  drop,
  input  logic  squash,
  input  word_t data_in,
  input  word_t pc_in,
  output word_t data_out,
  output word_t pc_out,
  output logic  valid
);

  // Squash beats capture beats drop; payload is kept when only valid clears.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_out <= '0;
      pc_out   <= '0;
      valid    <= 1'b0;
    end else if (squash) begin
      valid <= 1'b0;
    end else if (capture) begin
      data_out <= data_in;
      pc_out   <= pc_in;
      valid    <= 1'b1;
    end else if (drop) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch-stage sequencer: drives PC register load, waits on instruction
// memory, holds instructions for stalled decode, applies redirects.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter word_t       RESET_PC   = RESET_PC_DEF,
  parameter int unsigned PC_STEP    = PC_STEP_DEF,
  parameter int unsigned ALIGN_BITS = ALIGN_BITS_DEF
) (
  input  logic  clk,
  input  logic  reset,
  input  word_t pc_next,
  input  word_t inst_in,
  input  logic  mem_ready,
  input  logic  stall,
  input  logic  redirect_valid,
  input  word_t redirect_pc,
  output word_t pc_new,
  output logic  pc_load,
  output word_t cur_pc,
  output word_t inst_out,
  output logic  inst_valid,
  output word_t inst_pc,
  output logic  fault
);

  localparam word_t ALIGN_MASK = 32'((64'd1 << ALIGN_BITS) - 64'd1);

  state_t state, state_d;
  word_t  cur_pc_d;
  logic   fault_d;
  logic   load;
  logic   capture, drop, squash;
  logic   seq_ok, misaligned;

  assign seq_ok     = (pc_next == 32'(cur_pc + 32'(PC_STEP)));
  assign misaligned = ((redirect_pc & ALIGN_MASK) != '0);

  // PC load enable is never asserted while reset is held.
  assign pc_load = load & ~reset;

  // State, mirrored PC and sticky fault registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= BOOT;
      cur_pc <= RESET_PC;
      fault  <= 1'b0;
    end else begin
      state  <= state_d;
      cur_pc <= cur_pc_d;
      fault  <= fault_d;
    end
  end

  // Next-state, PC load request and holding-stage controls.
  always_comb begin
    state_d  = state;
    cur_pc_d = cur_pc;
    fault_d  = fault;
    load     = 1'b0;
    pc_new   = cur_pc;
    capture  = 1'b0;
    drop     = 1'b0;
    squash   = 1'b0;

    unique case (state)
      BOOT: begin
        load     = 1'b1;
        pc_new   = RESET_PC;
        cur_pc_d = RESET_PC;
        state_d  = FETCH;
      end

      FETCH, HOLD: begin
        if (redirect_valid) begin
          squash = 1'b1;
          if (misaligned) begin
            fault_d = 1'b1;
            state_d = FAULT;
          end else begin
            load     = 1'b1;
            pc_new   = redirect_pc;
            cur_pc_d = redirect_pc;
            state_d  = FETCH;
          end
        end else if (state == HOLD) begin
          if (!stall) begin
            if (!seq_ok) begin
              squash  = 1'b1;
              fault_d = 1'b1;
              state_d = FAULT;
            end else begin
              drop     = 1'b1;
              load     = 1'b1;
              pc_new   = pc_next;
              cur_pc_d = pc_next;
              state_d  = FETCH;
            end
          end
        end else if (mem_ready) begin
          if (stall) begin
            capture = 1'b1;
            state_d = HOLD;
          end else if (!seq_ok) begin
            squash  = 1'b1;
            fault_d = 1'b1;
            state_d = FAULT;
          end else begin
            capture  = 1'b1;
            load     = 1'b1;
            pc_new   = pc_next;
            cur_pc_d = pc_next;
          end
        end else if (!stall) begin
          drop = 1'b1;
        end
      end

      FAULT: begin
        squash = 1'b1;
      end

      default: begin
        state_d = FAULT;
      end
    endcase
  end

  fetch_hold_buf u_hold_buf (
    .clk      (clk),
    .reset    (reset),
    .capture  (capture),
    .drop     (drop),
    .squash   (squash),
    .data_in  (inst_in),
    .pc_in    (cur_pc),
    .data_out (inst_out),
    .pc_out   (inst_pc),
    .valid    (inst_valid)
  );

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: directed scenarios plus randomized run against a reference model.
module tb_fetch_ctrl;
  import fetch_pkg::*;

  localparam word_t RST_PC = 32'h0000_0000;

  logic  clk = 1'b0;
  logic  reset = 1'b0;
  word_t pc_next, inst_in, redirect_pc, pc_new, cur_pc, inst_out, inst_pc;
  logic  mem_ready, stall, redirect_valid, pc_load, inst_valid, fault;

  logic  pn_force = 1'b0;
  word_t pn_val   = '0;

  int errors = 0;
  int checks = 0;

  fetch_ctrl #(.RESET_PC(RST_PC), .PC_STEP(4), .ALIGN_BITS(2)) dut (
    .clk            (clk),
    .reset          (reset),
    .pc_next        (pc_next),
    .inst_in        (inst_in),
    .mem_ready      (mem_ready),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .pc_new         (pc_new),
    .pc_load        (pc_load),
    .cur_pc         (cur_pc),
    .inst_out       (inst_out),
    .inst_valid     (inst_valid),
    .inst_pc        (inst_pc),
    .fault          (fault)
  );

  always #5 clk = ~clk;

  function automatic word_t rom(input word_t a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  // Fetch datapath stand-in: adder and ROM are addressed by the PC register.
  assign pc_next = pn_force ? pn_val : 32'(cur_pc + 32'd4);
  assign inst_in = rom(cur_pc);

  task automatic drive(input logic mr, input logic st, input logic rv, input word_t rpc);
    mem_ready = mr; stall = st; redirect_valid = rv; redirect_pc = rpc;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic apply_reset();
    drive(1'b0, 1'b0, 1'b0, '0);
    pn_force = 1'b0;
    reset = 1'b1;
    next_cycle();
    reset = 1'b0;
  endtask

  task automatic boot_and_advance(input int n);
    apply_reset();
    drive(1'b1, 1'b0, 1'b0, '0);
    next_cycle();
    repeat (n) next_cycle();
  endtask

  task automatic test_reset();
    boot_and_advance(2);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    checks++; if (cur_pc !== RST_PC) begin errors++; $display("FAIL reset_cur_pc got=%h want=%h", cur_pc, RST_PC); end
    checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b want=0", inst_valid); end
    checks++; if (inst_out !== 32'h0) begin errors++; $display("FAIL reset_inst_out got=%h want=0", inst_out); end
    checks++; if (inst_pc !== 32'h0) begin errors++; $display("FAIL reset_inst_pc got=%h want=0", inst_pc); end
    checks++; if (fault !== 1'b0) begin errors++; $display("FAIL reset_fault got=%b want=0", fault); end
    checks++; if (pc_load !== 1'b0) begin errors++; $display("FAIL reset_pc_load got=%b want=0", pc_load); end
    checks++; if (pc_new !== RST_PC) begin errors++; $display("FAIL reset_pc_new got=%h want=%h", pc_new, RST_PC); end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_stream();
    apply_reset();
    drive(1'b1, 1'b0, 1'b0, '0);
    #1;
    checks++; if (pc_load !== 1'b1) begin errors++; $display("FAIL boot_load got=%b want=1", pc_load); end
    checks++; if (pc_new !== RST_PC) begin errors++; $display("FAIL boot_pc_new got=%h want=%h", pc_new, RST_PC); end
    next_cycle();
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++; if (pc_load !== 1'b1) begin errors++; $display("FAIL stream_load k=%0d got=%b want=1", k, pc_load); end
      checks++; if (pc_new !== 32'(4 * (k + 1))) begin errors++; $display("FAIL stream_pc_new k=%0d got=%h want=%h", k, pc_new, 32'(4 * (k + 1))); end
      if (k == 0) begin
        checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL stream_valid0 got=%b want=0", inst_valid); end
      end else begin
        checks++; if (inst_valid !== 1'b1) begin errors++; $display("FAIL stream_valid k=%0d got=%b want=1", k, inst_valid); end
        checks++; if (inst_pc !== 32'(4 * (k - 1))) begin errors++; $display("FAIL stream_inst_pc k=%0d got=%h want=%h", k, inst_pc, 32'(4 * (k - 1))); end
        checks++; if (inst_out !== rom(32'(4 * (k - 1)))) begin errors++; $display("FAIL stream_inst_out k=%0d got=%h want=%h", k, inst_out, rom(32'(4 * (k - 1)))); end
      end
      next_cycle();
    end
  endtask

  task automatic test_mem_wait();
    boot_and_advance(2);
    drive(1'b0, 1'b0, 1'b0, '0);
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (pc_load !== 1'b0) begin errors++; $display("FAIL wait_load i=%0d got=%b want=0", i, pc_load); end
      if (i > 0) begin
        checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL wait_valid i=%0d got=%b want=0", i, inst_valid); end
      end
      next_cycle();
    end
    drive(1'b1, 1'b0, 1'b0, '0);
    #1;
    checks++; if (pc_load !== 1'b1 || pc_new !== 32'd12) begin errors++; $display("FAIL wait_resume_load got=%b/%h want=1/0000000c", pc_load, pc_new); end
    next_cycle();
    checks++; if (inst_valid !== 1'b1) begin errors++; $display("FAIL wait_valid_after got=%b want=1", inst_valid); end
    checks++; if (inst_pc !== 32'd8) begin errors++; $display("FAIL wait_inst_pc got=%h want=8", inst_pc); end
    checks++; if (inst_out !== rom(32'd8)) begin errors++; $display("FAIL wait_inst_out got=%h want=%h", inst_out, rom(32'd8)); end
  endtask

  task automatic test_stall_hold();
    boot_and_advance(1);
    drive(1'b1, 1'b1, 1'b0, '0);
    #1;
    checks++; if (pc_load !== 1'b0) begin errors++; $display("FAIL hold_enter_load got=%b want=0", pc_load); end
    next_cycle();
    for (int i = 0; i < 5; i++) begin
      drive(1'($urandom % 2), 1'b1, 1'b0, '0);
      #1;
      checks++; if (pc_load !== 1'b0) begin errors++; $display("FAIL hold_load i=%0d got=%b want=0", i, pc_load); end
      checks++; if (inst_valid !== 1'b1) begin errors++; $display("FAIL hold_valid i=%0d got=%b want=1", i, inst_valid); end
      checks++; if (inst_pc !== 32'd4) begin errors++; $display("FAIL hold_inst_pc i=%0d got=%h want=4", i, inst_pc); end
      checks++; if (inst_out !== rom(32'd4)) begin errors++; $display("FAIL hold_inst_out i=%0d got=%h want=%h", i, inst_out, rom(32'd4)); end
      next_cycle();
    end
    drive(1'b0, 1'b0, 1'b0, '0);
    #1;
    checks++; if (pc_load !== 1'b1 || pc_new !== 32'd8) begin errors++; $display("FAIL hold_release got=%b/%h want=1/00000008", pc_load, pc_new); end
    next_cycle();
    checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL hold_after_valid got=%b want=0", inst_valid); end
    checks++; if (cur_pc !== 32'd8) begin errors++; $display("FAIL hold_after_pc got=%h want=8", cur_pc); end
  endtask

  task automatic test_redirect();
    boot_and_advance(2);
    drive(1'b1, 1'b0, 1'b1, 32'h100);
    #1;
    checks++; if (pc_load !== 1'b1 || pc_new !== 32'h100) begin errors++; $display("FAIL redir_load got=%b/%h want=1/00000100", pc_load, pc_new); end
    next_cycle();
    checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL redir_squash got=%b want=0", inst_valid); end
    checks++; if (cur_pc !== 32'h100) begin errors++; $display("FAIL redir_cur_pc got=%h want=00000100", cur_pc); end
    drive(1'b1, 1'b0, 1'b0, '0);
    #1;
    checks++; if (pc_new !== 32'h104) begin errors++; $display("FAIL redir_next got=%h want=00000104", pc_new); end
    next_cycle();
    checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'h100) begin errors++; $display("FAIL redir_first got=%b/%h want=1/00000100", inst_valid, inst_pc); end
    checks++; if (inst_out !== rom(32'h100)) begin errors++; $display("FAIL redir_inst_out got=%h want=%h", inst_out, rom(32'h100)); end
  endtask

  task automatic test_misalign_fault();
    boot_and_advance(1);
    drive(1'b1, 1'b0, 1'b1, 32'h102);
    #1;
    checks++; if (pc_load !== 1'b0) begin errors++; $display("FAIL misalign_load got=%b want=0", pc_load); end
    next_cycle();
    for (int i = 0; i < 10; i++) begin
      drive(1'($urandom % 2), 1'($urandom % 2), 1'($urandom % 2), 32'h200);
      #1;
      checks++; if (fault !== 1'b1) begin errors++; $display("FAIL fault_sticky i=%0d got=%b want=1", i, fault); end
      checks++; if (pc_load !== 1'b0) begin errors++; $display("FAIL fault_load i=%0d got=%b want=0", i, pc_load); end
      checks++; if (inst_valid !== 1'b0 || cur_pc !== 32'd4) begin errors++; $display("FAIL fault_frozen i=%0d got=%b/%h want=0/00000004", i, inst_valid, cur_pc); end
      next_cycle();
    end
    drive(1'b0, 1'b0, 1'b0, '0);
    reset = 1'b1;
    #1;
    checks++; if (fault !== 1'b0) begin errors++; $display("FAIL fault_clear got=%b want=0", fault); end
    checks++; if (pc_new !== RST_PC || pc_load !== 1'b0) begin errors++; $display("FAIL fault_reset_pc got=%h/%b want=%h/0", pc_new, pc_load, RST_PC); end
    next_cycle();
    reset = 1'b0;
  endtask

  task automatic test_wrap();
    boot_and_advance(0);
    drive(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC);
    next_cycle();
    drive(1'b1, 1'b0, 1'b0, '0);
    #1;
    checks++; if (pc_load !== 1'b1 || pc_new !== 32'h0) begin errors++; $display("FAIL wrap_load got=%b/%h want=1/00000000", pc_load, pc_new); end
    next_cycle();
    checks++; if (fault !== 1'b0 || cur_pc !== 32'h0) begin errors++; $display("FAIL wrap_state got=%b/%h want=0/00000000", fault, cur_pc); end
    checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_inst got=%b/%h want=1/fffffffc", inst_valid, inst_pc); end
  endtask

  task automatic test_adder_fault();
    boot_and_advance(0);
    drive(1'b0, 1'b0, 1'b1, 32'h10);
    next_cycle();
    pn_force = 1'b1;
    pn_val   = 32'h20;
    drive(1'b1, 1'b0, 1'b0, '0);
    #1;
    checks++; if (pc_load !== 1'b0) begin errors++; $display("FAIL adder_load got=%b want=0", pc_load); end
    next_cycle();
    checks++; if (fault !== 1'b1 || inst_valid !== 1'b0) begin errors++; $display("FAIL adder_fault got=%b/%b want=1/0", fault, inst_valid); end
    checks++; if (cur_pc !== 32'h10) begin errors++; $display("FAIL adder_cur_pc got=%h want=00000010", cur_pc); end
    pn_force = 1'b0;
  endtask

  task automatic test_random();
    bit    booting, holding, dead, m_valid, m_fault;
    word_t m_pc, m_out, m_ipc;
    bit    e_load;
    word_t e_new;
    logic  mr, st, rv, corrupt;
    word_t rpc;
    for (int r = 0; r < 6; r++) begin
      apply_reset();
      booting = 1; holding = 0; dead = 0; m_valid = 0; m_fault = 0;
      m_pc = RST_PC; m_out = '0; m_ipc = '0;
      for (int c = 0; c < 80; c++) begin
        mr = 1'(($urandom % 4) != 0);
        st = 1'(($urandom % 3) == 0);
        rv = 1'(($urandom % 8) == 0);
        rpc = $urandom & 32'hFFFF_FFFC;
        if ($urandom % 16 == 0) rpc = rpc | 32'h2;
        corrupt = 1'(($urandom % 64) == 0);
        pn_force = corrupt;
        pn_val   = 32'(m_pc + 32'd8);
        drive(mr, st, rv, rpc);
        #1;
        // Reference: what the fetch stage must do this cycle.
        e_load = 0;
        e_new  = '0;
        if (booting) begin
          e_load = 1; e_new = RST_PC; m_pc = RST_PC; booting = 0;
        end else if (dead) begin
          m_valid = 0;
        end else if (rv) begin
          m_valid = 0; holding = 0;
          if (rpc % 4 != 0) begin
            dead = 1; m_fault = 1;
          end else begin
            e_load = 1; e_new = rpc;
          end
        end else if (holding && !st) begin
          m_valid = 0; holding = 0;
          if (corrupt) begin
            dead = 1; m_fault = 1;
          end else begin
            e_load = 1; e_new = 32'(m_pc + 32'd4);
          end
        end else if (!holding && mr && st) begin
          m_valid = 1; m_out = rom(m_pc); m_ipc = m_pc; holding = 1;
        end else if (!holding && mr) begin
          if (corrupt) begin
            dead = 1; m_fault = 1; m_valid = 0;
          end else begin
            m_valid = 1; m_out = rom(m_pc); m_ipc = m_pc;
            e_load = 1; e_new = 32'(m_pc + 32'd4);
          end
        end else if (!holding && !st) begin
          m_valid = 0;
        end
        checks++; if (pc_load !== e_load) begin errors++; $display("FAIL rnd_load r=%0d c=%0d got=%b want=%b", r, c, pc_load, e_load); end
        if (e_load) begin
          checks++; if (pc_new !== e_new) begin errors++; $display("FAIL rnd_pc_new r=%0d c=%0d got=%h want=%h", r, c, pc_new, e_new); end
          m_pc = e_new;
        end
        next_cycle();
        checks++; if (cur_pc !== m_pc) begin errors++; $display("FAIL rnd_cur_pc r=%0d c=%0d got=%h want=%h", r, c, cur_pc, m_pc); end
        checks++; if (inst_valid !== m_valid) begin errors++; $display("FAIL rnd_valid r=%0d c=%0d got=%b want=%b", r, c, inst_valid, m_valid); end
        checks++; if (fault !== m_fault) begin errors++; $display("FAIL rnd_fault r=%0d c=%0d got=%b want=%b", r, c, fault, m_fault); end
        if (m_valid) begin
          checks++; if (inst_pc !== m_ipc || inst_out !== m_out) begin errors++; $display("FAIL rnd_inst r=%0d c=%0d got=%h/%h want=%h/%h", r, c, inst_pc, inst_out, m_ipc, m_out); end
        end
      end
    end
    pn_force = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    drive(1'b0, 1'b0, 1'b0, '0);
    @(negedge clk);
    test_reset();
    test_stream();
    test_mem_wait();
    test_stall_hold();
    test_redirect();
    test_misalign_fault();
    test_wrap();
    test_adder_fault();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
